// File: rtl/keccak_pkg.sv
// Shared constants and types for the keccak input path.
// Defines the word/byte-count widths of the keccak input interface, the packed
// output-word record, and the final-word byte-count encoding.
package keccak_pkg;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned BYTE_NUM_W = 3;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned CNT_W      = 4;

  // Accumulator count value meaning "eight bytes held, word complete".
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BYTES);

  typedef struct packed {
    logic [WORD_W-1:0]     data;
    logic                  last;
    logic [BYTE_NUM_W-1:0] byteNum;
  } wordT;

  // Final word encoding: byteNum counts leading valid bytes. A last word with
  // byteNum==0 carries no data bytes, which is how both an empty message and a
  // message whose length is a multiple of 8 are terminated.
  function automatic logic [BYTE_NUM_W-1:0] finalByteNum(input logic [CNT_W-1:0] cnt);
    return cnt[BYTE_NUM_W-1:0];
  endfunction

endpackage

// File: rtl/keccak_word_slot.sv
// Output holding register between the byte packer and the keccak core.
// Ports:
//   iClk, iRst    clock, synchronous active-high reset
//   iLoad, iWord  load a new word into the slot (only issued when oFree)
//   iBuffer_full  keccak backpressure; a held word transfers when it is low
//   oFree         slot can take a word this cycle (empty, or transferring now)
//   oData, oReady, oLast, oByte_num  registered word presented to keccak
module keccak_word_slot
  import keccak_pkg::*;
(
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iLoad,
  input  wordT                  iWord,
  input  logic                  iBuffer_full,
  output logic                  oFree,
  output logic [WORD_W-1:0]     oData,
  output logic                  oReady,
  output logic                  oLast,
  output logic [BYTE_NUM_W-1:0] oByte_num
);

  assign oFree = !oReady || !iBuffer_full;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oData     <= '0;
      oReady    <= 1'b0;
      oLast     <= 1'b0;
      oByte_num <= '0;
    end else if (iLoad) begin
      oData     <= iWord.data;
      oLast     <= iWord.last;
      oByte_num <= iWord.byteNum;
      oReady    <= 1'b1;
    end else if (oFree) begin
      // Word transferred (or slot already empty); fields hold, only valid drops.
      oReady <= 1'b0;
    end
  end

endmodule

// File: rtl/keccak_byte_packer.sv
// Byte-stream to 64-bit word packer feeding the keccak core.
// Packs bytes big-endian (first byte in [63:56]) and emits the final word with
// iLast/iByte_num per the keccak input rules. One message per reset.
// Ports:
//   iClk, iRst                    clock, synchronous active-high reset
//   iByte, iByte_valid, iByte_last, oByte_ready   byte-stream input handshake
//   oData, oReady, oLast, oByte_num               word output to keccak
//   iBuffer_full                  keccak backpressure
module keccak_byte_packer
  import keccak_pkg::*;
(
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [7:0]            iByte,
  input  logic                  iByte_valid,
  input  logic                  iByte_last,
  output logic                  oByte_ready,
  output logic [WORD_W-1:0]     oData,
  output logic                  oReady,
  output logic                  oLast,
  output logic [BYTE_NUM_W-1:0] oByte_num,
  input  logic                  iBuffer_full
);

  logic [CNT_W-1:0]  cntQ, cntD;
  logic [WORD_W-1:0] accQ, accD;
  logic              endPendQ, endPendD;
  logic              doneQ, doneD;

  logic slotFree, slotLoad;
  wordT slotWord;
  logic accept, moveFull, moveFinal;

  assign oByte_ready = (cntQ < CNT_FULL) && !endPendQ && !doneQ;
  assign accept      = oByte_ready && (iByte_valid || iByte_last);
  assign moveFull    = slotFree && (cntQ == CNT_FULL);
  assign moveFinal   = slotFree && endPendQ && (cntQ < CNT_FULL);

  // Moves and byte acceptance are mutually exclusive: both moves require a
  // state in which oByte_ready is low (cnt==8 or end pending).
  always_comb begin
    cntD     = cntQ;
    accD     = accQ;
    endPendD = endPendQ;
    doneD    = doneQ;
    slotLoad = 1'b0;
    slotWord = '0;
    if (moveFull) begin
      slotLoad         = 1'b1;
      slotWord.data    = accQ;
      slotWord.last    = 1'b0;
      slotWord.byteNum = '0;
      cntD             = '0;
      accD             = '0;
    end else if (moveFinal) begin
      // Unused lanes are already zero because acc is cleared on every move.
      slotLoad         = 1'b1;
      slotWord.data    = accQ;
      slotWord.last    = 1'b1;
      slotWord.byteNum = finalByteNum(cntQ);
      cntD             = '0;
      accD             = '0;
      endPendD         = 1'b0;
      doneD            = 1'b1;
    end else if (accept) begin
      if (iByte_valid) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
          if (cntQ[BYTE_NUM_W-1:0] == BYTE_NUM_W'(i)) begin
            accD[WORD_W-1-8*i -: 8] = iByte;
          end
        end
        cntD = cntQ + 4'd1;
      end
      if (iByte_last) begin
        endPendD = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cntQ     <= '0;
      accQ     <= '0;
      endPendQ <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      cntQ     <= cntD;
      accQ     <= accD;
      endPendQ <= endPendD;
      doneQ    <= doneD;
    end
  end

  keccak_word_slot uSlot (
    .iClk         (iClk),
    .iRst         (iRst),
    .iLoad        (slotLoad),
    .iWord        (slotWord),
    .iBuffer_full (iBuffer_full),
    .oFree        (slotFree),
    .oData        (oData),
    .oReady       (oReady),
    .oLast        (oLast),
    .oByte_num    (oByte_num)
  );

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Scoreboard bench for keccak_byte_packer: stimulus pushes expected words,
// a negedge monitor pops and compares whenever a word transfers.
module tb_keccak_byte_packer;

  logic        iClk;
  logic        iRst;
  logic [7:0]  iByte;
  logic        iByte_valid;
  logic        iByte_last;
  logic        oByte_ready;
  logic [63:0] oData;
  logic        oReady;
  logic        oLast;
  logic [2:0]  oByte_num;
  logic        iBuffer_full;

  keccak_byte_packer dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iByte        (iByte),
    .iByte_valid  (iByte_valid),
    .iByte_last   (iByte_last),
    .oByte_ready  (oByte_ready),
    .oData        (oData),
    .oReady       (oReady),
    .oLast        (oLast),
    .oByte_num    (oByte_num),
    .iBuffer_full (iBuffer_full)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [2:0]  num;
  } expT;

  expT sb[$];
  int  nCompared = 0;
  int  nMismatch = 0;

  localparam logic [63:0] W_QUIC = 64'h5468652071756963;
  localparam logic [63:0] W_KBRO = 64'h6B2062726F776E20;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNote(input string name);
    nCompared++;
    nMismatch++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic pushExp(input logic [63:0] d, input logic l, input logic [2:0] n);
    expT e;
    e.data = d;
    e.last = l;
    e.num  = n;
    sb.push_back(e);
  endtask

  // Monitor: a word transfers on the next posedge when oReady && !iBuffer_full.
  initial begin
    expT e;
    forever begin
      @(negedge iClk);
      if (!iRst && oReady && !iBuffer_full) begin
        if (sb.size() == 0) begin
          failNote("unexpected word");
        end else begin
          e = sb.pop_front();
          check("word data", oData, e.data);
          check("word last", 64'(oLast), 64'(e.last));
          check("word byte_num", 64'(oByte_num), 64'(e.num));
        end
      end
    end
  end

  task automatic doReset();
    iRst        = 1'b1;
    iByte_valid = 1'b0;
    iByte_last  = 1'b0;
    @(posedge iClk);
    #1;
    sb.delete();
    iRst = 1'b0;
    check("reset oReady", 64'(oReady), 64'd0);
    check("reset oData", oData, 64'd0);
    check("reset oLast", 64'(oLast), 64'd0);
    check("reset oByte_num", 64'(oByte_num), 64'd0);
    check("reset oByte_ready", 64'(oByte_ready), 64'd1);
  endtask

  // Present one item and hold it until accepted (bounded).
  task automatic sendItem(input logic [7:0] b, input logic v, input logic l);
    int n;
    iByte       = b;
    iByte_valid = v;
    iByte_last  = l;
    n = 0;
    @(negedge iClk);
    while (!oByte_ready && n < 50) begin
      n++;
      @(negedge iClk);
    end
    if (!oByte_ready) failNote("byte accept timeout");
    @(posedge iClk);
    #1;
    iByte_valid = 1'b0;
    iByte_last  = 1'b0;
  endtask

  task automatic sendString(input string s, input bit lastOnEnd);
    for (int i = 0; i < s.len(); i++) begin
      sendItem(s[i], 1'b1, lastOnEnd && (i == s.len() - 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || oReady) && n < 200) begin
      @(posedge iClk);
      #2;
      n++;
    end
    if (sb.size() != 0 || oReady) failNote("drain timeout");
  endtask

  initial begin
    iRst         = 1'b1;
    iByte        = 8'h00;
    iByte_valid  = 1'b0;
    iByte_last   = 1'b0;
    iBuffer_full = 1'b0;

    // Fox message: 5 full words then "dog" as final partial word.
    doReset();
    pushExp(W_QUIC, 1'b0, 3'd0);
    pushExp(W_KBRO, 1'b0, 3'd0);
    pushExp(64'h666F78206A756D70, 1'b0, 3'd0);
    pushExp(64'h73206F7665722074, 1'b0, 3'd0);
    pushExp(64'h6865206C617A7920, 1'b0, 3'd0);
    pushExp(64'h646F670000000000, 1'b1, 3'd3);
    sendString("The quick brown fox jumps over the lazy dog", 1'b1);
    drain();

    // Done: bytes offered after the final word are refused, no new words.
    iByte       = 8'h41;
    iByte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      check("done oByte_ready", 64'(oByte_ready), 64'd0);
      check("done oReady", 64'(oReady), 64'd0);
    end
    @(posedge iClk);
    #1;
    iByte_valid = 1'b0;

    // Empty message.
    doReset();
    pushExp(64'd0, 1'b1, 3'd0);
    sendItem(8'h00, 1'b0, 1'b1);
    drain();

    // Multiple-of-8 message: full word then empty final word.
    doReset();
    pushExp(W_QUIC, 1'b0, 3'd0);
    pushExp(64'd0, 1'b1, 3'd0);
    sendString("The quic", 1'b1);
    drain();

    // Backpressure: first word stalls while the next 8 bytes fill the accumulator.
    doReset();
    iBuffer_full = 1'b1;
    pushExp(W_QUIC, 1'b0, 3'd0);
    pushExp(W_KBRO, 1'b0, 3'd0);
    pushExp(64'd0, 1'b1, 3'd0);
    sendString("The quic", 1'b0);
    sendString("k brown ", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      check("stall oReady", 64'(oReady), 64'd1);
      check("stall oData", oData, W_QUIC);
      check("stall oLast", 64'(oLast), 64'd0);
      check("stall oByte_ready", 64'(oByte_ready), 64'd0);
    end
    @(posedge iClk);
    #1;
    iBuffer_full = 1'b0;
    sendItem(8'h00, 1'b0, 1'b1);
    drain();

    // Reset mid-word with a held output word.
    doReset();
    iBuffer_full = 1'b1;
    sendString("The quic", 1'b0);
    sendString("k bro", 1'b0);
    @(negedge iClk);
    check("pre-reset oReady", 64'(oReady), 64'd1);
    @(posedge iClk);
    #1;
    doReset();
    iBuffer_full = 1'b0;
    pushExp(64'h6162630000000000, 1'b1, 3'd3);
    sendString("abc", 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
